// File: rtl/pack_stream.sv
`default_nettype none
// ============================================================================
// Module   : pack_stream
// Purpose  : Compacts sparse valid lanes into a buffer; emits dense N-lane beats.
// Revision : 1.0 - initial release
// ============================================================================
module pack_stream #(
  parameter int N     = 8,
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [N-1:0]                 in_lane_vld,
  input  logic [N-1:0][W-1:0]          in_data,
  input  logic                         in_flush,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [N-1:0][W-1:0]          out_data,
  output logic [N-1:0]                 out_lane_vld,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int            OW      = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] C_N     = OW'(N);
  localparam logic [OW-1:0] C_ROOM  = OW'(DEPTH - N);
  localparam logic [OW-1:0] C_DEPTH = OW'(DEPTH);
  localparam logic [0:0]    ACCUM   = 1'b0;
  localparam logic [0:0]    DRAIN   = 1'b1;

  logic [0:0]    r_state, w_state_nxt;
  logic [OW-1:0] r_occ, w_occ_nxt, w_take, w_base, w_cnt;
  logic [W-1:0]  r_mem     [DEPTH];
  logic [W-1:0]  w_mem_nxt [DEPTH];
  logic [OW-1:0] w_pos     [N];
  logic          w_push, w_pop, w_drain;

  assign w_drain = (r_state == DRAIN);
  assign w_take  = (r_occ < C_N) ? r_occ : C_N;
  assign in_rdy  = !w_drain && (r_occ <= C_ROOM);
  assign out_vld = (r_occ >= C_N) || (w_drain && (r_occ != '0));
  assign out_last = w_drain && (r_occ <= C_N);
  assign occ     = r_occ;
  assign w_push  = in_vld && in_rdy;
  assign w_pop   = out_vld && out_rdy;
  // Pop is applied first, so incoming lanes land after the surviving entries.
  assign w_base  = w_pop ? (r_occ - w_take) : r_occ;

  generate
    for (genvar k = 0; k < N; k++) begin : g_out
      assign out_lane_vld[k] = (OW'(k) < w_take);
      assign out_data[k]     = (OW'(k) < w_take) ? r_mem[k] : '0;
    end
  endgenerate

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N; i++) begin
      w_pos[i] = w_base + w_cnt;
      w_cnt    = w_cnt + OW'(in_lane_vld[i]);
    end
  end

  assign w_occ_nxt = w_base + (w_push ? w_cnt : '0);

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      w_mem_nxt[j] = r_mem[j];
      if (w_pop) begin
        for (int d = 1; d <= N; d++) begin
          if ((w_take == OW'(d)) && (j + d < DEPTH))
            w_mem_nxt[j] = r_mem[(j + d) % DEPTH];
        end
      end
      if (w_push) begin
        for (int i = 0; i < N; i++) begin
          if (in_lane_vld[i] && (w_pos[i] == OW'(j)))
            w_mem_nxt[j] = in_data[i];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_drain) begin
      if (w_push && in_flush && (w_occ_nxt != '0))
        w_state_nxt = DRAIN;
    end else if (w_pop && out_last) begin
      w_state_nxt = ACCUM;
    end
  end

  // Payload storage carries no reset; occupancy alone defines what is live.
  always_ff @(posedge clk) begin
    r_mem <= w_mem_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ACCUM;
      r_occ   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_occ   <= w_occ_nxt;
    end
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst) r_occ <= C_DEPTH);

endmodule
`default_nettype wire
